// File: rtl/angle_pi_controller_pkg.sv
// Shared widths, the one-hot state encoding and small constant helpers for the angle PI controller.
package angle_pi_controller_pkg;

    localparam int RATE_BIT_WIDTH    = 16;
    localparam int REC_VAL_BIT_WIDTH = 8;
    localparam int GAIN_BIT_WIDTH    = 8;
    localparam int GAIN_FRAC_BITS    = 4;

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_LATCH    = 6'b000010,
        S_MAP      = 6'b000100,
        S_PI       = 6'b001000,
        S_LIMIT    = 6'b010000,
        S_COMPLETE = 6'b100000
    } state_t;

    // Largest positive value of a signed word, used as a symmetric clamp limit.
    function automatic int sym_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/angle_pi_controller_if.sv
// Run control, per-axis input buses and result buses of the angle PI controller.
interface angle_pi_controller_if
    import angle_pi_controller_pkg::*;
#(
    parameter int NUM_AXES   = 3,
    parameter int REC_WIDTH  = REC_VAL_BIT_WIDTH,
    parameter int RATE_WIDTH = RATE_BIT_WIDTH
);
    logic                                 start_signal;
    logic                                 integ_clear;
    logic [NUM_AXES*REC_WIDTH-1:0]        target_bus;
    logic [NUM_AXES*RATE_WIDTH-1:0]       actual_bus;
    logic [NUM_AXES-1:0]                  invert_mask;
    logic [NUM_AXES*GAIN_BIT_WIDTH-1:0]   kp_bus;
    logic [NUM_AXES*GAIN_BIT_WIDTH-1:0]   ki_bus;
    logic [NUM_AXES*RATE_WIDTH-1:0]       rate_out_bus;
    logic [NUM_AXES*RATE_WIDTH-1:0]       angle_error_bus;
    logic [NUM_AXES-1:0]                  saturated;
    logic                                 active_signal;
    logic                                 complete_signal;

    modport master (
        output start_signal, integ_clear, target_bus, actual_bus, invert_mask, kp_bus, ki_bus,
        input  rate_out_bus, angle_error_bus, saturated, active_signal, complete_signal
    );

    modport slave (
        input  start_signal, integ_clear, target_bus, actual_bus, invert_mask, kp_bus, ki_bus,
        output rate_out_bus, angle_error_bus, saturated, active_signal, complete_signal
    );
endinterface

// File: rtl/angle_pi_controller_signed_saturate.sv
// Combinational symmetric clamp of a wide signed value into a narrower signed word.
module signed_saturate #(
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 16,
    parameter int LIMIT     = 400
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);
    localparam logic signed [IN_WIDTH-1:0] HI = IN_WIDTH'(LIMIT);
    localparam logic signed [IN_WIDTH-1:0] LO = -HI;

    always_comb begin
        if (din > HI)
            dout = OUT_WIDTH'(HI);
        else if (din < LO)
            dout = OUT_WIDTH'(LO);
        else
            dout = OUT_WIDTH'(din);
    end
endmodule

// File: rtl/angle_pi_controller.sv
// Shared-datapath angle-to-rate PI controller; visits each axis through MAP, PI and LIMIT in turn.
//   state    | meaning
//   IDLE     | waiting for a start rising edge
//   LATCH    | capture all input buses, reset axis index
//   MAP      | map target, form and saturate angle error for axis idx
//   PI       | integrator update with anti-windup, P and I products
//   LIMIT    | clamp P+I, write axis outputs, advance or finish
//   COMPLETE | one-cycle tail before returning to IDLE
module angle_pi_controller
    import angle_pi_controller_pkg::*;
#(
    parameter int NUM_AXES   = 3,
    parameter int REC_WIDTH  = REC_VAL_BIT_WIDTH,
    parameter int RATE_WIDTH = RATE_BIT_WIDTH,
    parameter int CENTER     = 125,
    parameter int RATE_LIMIT = 400,
    parameter int INT_LIMIT  = 1600,
    parameter int ISHIFT     = 4
) (
    input  logic                  us_clk,
    input  logic                  reset,
    angle_pi_controller_if.slave  bus
);
    localparam int IDX_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam int EW    = RATE_WIDTH + 2;
    localparam int PW    = RATE_WIDTH + GAIN_BIT_WIDTH + 1;
    localparam int SW    = PW + 1;
    localparam int GW    = GAIN_BIT_WIDTH;

    state_t                       state;
    logic                         start_prev;
    logic [IDX_W-1:0]             idx;
    logic [REC_WIDTH-1:0]         tgt_q [NUM_AXES];
    logic signed [RATE_WIDTH-1:0] act_q [NUM_AXES];
    logic [GW-1:0]                kp_q  [NUM_AXES];
    logic [GW-1:0]                ki_q  [NUM_AXES];
    logic [NUM_AXES-1:0]          inv_q;
    logic signed [RATE_WIDTH-1:0] integ [NUM_AXES];
    logic signed [RATE_WIDTH-1:0] error_q;
    logic signed [PW-1:0]         p_q, i_q;
    logic [NUM_AXES*RATE_WIDTH-1:0] rate_q, err_out_q;
    logic [NUM_AXES-1:0]          sat_q;
    logic                         active_q, complete_q;

    logic signed [EW-1:0]         tgt_ext, mapped, act_ext, err_raw, integ_sum;
    logic signed [RATE_WIDTH-1:0] err_sat, integ_sat, integ_next, rate_prev, rate_sat;
    logic signed [PW-1:0]         p_full, i_full, p_w, i_w;
    logic signed [SW-1:0]         sum_w;
    logic                         skip_integ, clamped;

    always_comb begin
        tgt_ext = EW'(tgt_q[idx]);
        mapped  = (tgt_ext - EW'(CENTER)) <<< 1;
        act_ext = EW'(act_q[idx]);
        err_raw = inv_q[idx] ? (mapped + act_ext) : (mapped - act_ext);
    end

    signed_saturate #(.IN_WIDTH(EW), .OUT_WIDTH(RATE_WIDTH), .LIMIT(sym_max(RATE_WIDTH)))
        u_sat_err (.din(err_raw), .dout(err_sat));

    // Anti-windup: hold the integrator while pushing further into a clamped output.
    always_comb begin
        integ_sum  = EW'(integ[idx]) + EW'(error_q);
        rate_prev  = rate_q[idx*RATE_WIDTH +: RATE_WIDTH];
        skip_integ = sat_q[idx] && (error_q != '0) &&
                     (error_q[RATE_WIDTH-1] == rate_prev[RATE_WIDTH-1]);
        integ_next = skip_integ ? integ[idx] : integ_sat;
        p_full     = PW'(error_q) * PW'(signed'({1'b0, kp_q[idx]}));
        i_full     = PW'(integ_next) * PW'(signed'({1'b0, ki_q[idx]}));
        p_w        = p_full >>> GAIN_FRAC_BITS;
        i_w        = i_full >>> (GAIN_FRAC_BITS + ISHIFT);
        sum_w      = SW'(p_q) + SW'(i_q);
        clamped    = (SW'(rate_sat) != sum_w);
    end

    signed_saturate #(.IN_WIDTH(EW), .OUT_WIDTH(RATE_WIDTH), .LIMIT(INT_LIMIT))
        u_sat_int (.din(integ_sum), .dout(integ_sat));

    signed_saturate #(.IN_WIDTH(SW), .OUT_WIDTH(RATE_WIDTH), .LIMIT(RATE_LIMIT))
        u_sat_out (.din(sum_w), .dout(rate_sat));

    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            start_prev <= 1'b0;
            idx        <= '0;
            inv_q      <= '0;
            error_q    <= '0;
            p_q        <= '0;
            i_q        <= '0;
            rate_q     <= '0;
            err_out_q  <= '0;
            sat_q      <= '0;
            active_q   <= 1'b0;
            complete_q <= 1'b0;
            for (int i = 0; i < NUM_AXES; i++) begin
                tgt_q[i] <= '0;
                act_q[i] <= '0;
                kp_q[i]  <= '0;
                ki_q[i]  <= '0;
                integ[i] <= '0;
            end
        end else begin
            start_prev <= bus.start_signal;
            complete_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_signal && !start_prev)
                        state <= S_LATCH;
                end
                S_LATCH: begin
                    for (int i = 0; i < NUM_AXES; i++) begin
                        tgt_q[i] <= bus.target_bus[i*REC_WIDTH +: REC_WIDTH];
                        act_q[i] <= bus.actual_bus[i*RATE_WIDTH +: RATE_WIDTH];
                        kp_q[i]  <= bus.kp_bus[i*GW +: GW];
                        ki_q[i]  <= bus.ki_bus[i*GW +: GW];
                    end
                    inv_q    <= bus.invert_mask;
                    idx      <= '0;
                    active_q <= 1'b1;
                    state    <= S_MAP;
                end
                S_MAP: begin
                    error_q <= err_sat;
                    state   <= S_PI;
                end
                S_PI: begin
                    integ[idx] <= integ_next;
                    p_q        <= p_w;
                    i_q        <= i_w;
                    state      <= S_LIMIT;
                end
                S_LIMIT: begin
                    rate_q[idx*RATE_WIDTH +: RATE_WIDTH]    <= rate_sat;
                    err_out_q[idx*RATE_WIDTH +: RATE_WIDTH] <= error_q;
                    sat_q[idx]                              <= clamped;
                    if (idx == IDX_W'(NUM_AXES - 1)) begin
                        complete_q <= 1'b1;
                        active_q   <= 1'b0;
                        state      <= S_COMPLETE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= S_MAP;
                    end
                end
                S_COMPLETE: state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
            // Clear overrides any integrator write scheduled on this edge.
            if (bus.integ_clear) begin
                for (int i = 0; i < NUM_AXES; i++)
                    integ[i] <= '0;
            end
        end
    end

    assign bus.rate_out_bus    = rate_q;
    assign bus.angle_error_bus = err_out_q;
    assign bus.saturated       = sat_q;
    assign bus.active_signal   = active_q;
    assign bus.complete_signal = complete_q;
endmodule

// File: tb/tb_angle_pi_controller.sv
// Self-checking bench for angle_pi_controller against an integer reference model of the PI law.
module tb_angle_pi_controller;
    localparam int N    = 3;
    localparam int RW   = 16;
    localparam int RECW = 8;

    logic us_clk = 1'b0;
    logic reset;
    always #5 us_clk = ~us_clk;

    angle_pi_controller_if #(.NUM_AXES(N), .REC_WIDTH(RECW), .RATE_WIDTH(RW)) bus ();

    angle_pi_controller #(
        .NUM_AXES(N), .REC_WIDTH(RECW), .RATE_WIDTH(RW), .CENTER(125),
        .RATE_LIMIT(400), .INT_LIMIT(1600), .ISHIFT(4)
    ) dut (
        .us_clk(us_clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int tgt [N];
    int act [N];
    int kp  [N];
    int ki  [N];
    bit inv [N];

    int m_integ [N];
    int m_rate  [N];
    int m_err   [N];
    bit m_sat   [N];

    function automatic int clamp(input int v, input int lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_integ[i] = 0; m_rate[i] = 0; m_err[i] = 0; m_sat[i] = 1'b0;
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) m_integ[i] = 0;
    endfunction

    // One run of the control law, straight from the arithmetic definition.
    function automatic void model_run();
        for (int i = 0; i < N; i++) begin
            int e, p, it, s;
            e = 2 * (tgt[i] - 125) + (inv[i] ? act[i] : -act[i]);
            e = clamp(e, 32767);
            if (!(m_sat[i] && e != 0 && ((e > 0) == (m_rate[i] > 0))))
                m_integ[i] = clamp(m_integ[i] + e, 1600);
            p  = (e * kp[i]) >>> 4;
            it = (m_integ[i] * ki[i]) >>> 8;
            s  = p + it;
            m_rate[i] = clamp(s, 400);
            m_sat[i]  = (s > 400) || (s < -400);
            m_err[i]  = e;
        end
    endfunction

    function automatic void set_neutral();
        for (int i = 0; i < N; i++) begin
            tgt[i] = 125; act[i] = 0; kp[i] = 16; ki[i] = 0; inv[i] = 1'b0;
        end
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            bus.target_bus[i*RECW +: RECW] = tgt[i][7:0];
            bus.actual_bus[i*RW +: RW]     = act[i][15:0];
            bus.kp_bus[i*8 +: 8]           = kp[i][7:0];
            bus.ki_bus[i*8 +: 8]           = ki[i][7:0];
            bus.invert_mask[i]             = inv[i];
        end
    endtask

    task automatic pulse_clear();
        @(negedge us_clk) bus.integ_clear = 1'b1;
        @(negedge us_clk) bus.integ_clear = 1'b0;
        model_clear();
    endtask

    // mode 0: single-cycle start, 1: start held high, 2: second rising edge at k+4
    task automatic run_and_check(input string tag, input int mode);
        int pulses;
        logic signed [RW-1:0] got;
        drive_inputs();
        model_run();
        @(negedge us_clk) bus.start_signal = 1'b1;
        @(posedge us_clk);
        pulses = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge us_clk);
            case (mode)
                1:       bus.start_signal = (c < 30);
                2:       bus.start_signal = (c == 4 || c == 5);
                default: bus.start_signal = 1'b0;
            endcase
            @(posedge us_clk);
            #1;
            checks++;
            if (bus.active_signal !== (c <= 9)) begin
                errors++;
                $display("FAIL %s active c=%0d got %b exp %b", tag, c, bus.active_signal, (c <= 9));
            end
            checks++;
            if (bus.complete_signal !== (c == 10)) begin
                errors++;
                $display("FAIL %s complete c=%0d got %b exp %b", tag, c, bus.complete_signal, (c == 10));
            end
            if (bus.complete_signal === 1'b1) pulses++;
            if (c == 4) begin
                got = bus.rate_out_bus[0 +: RW];
                checks++;
                if (int'(got) !== m_rate[0]) begin
                    errors++;
                    $display("FAIL %s axis0 latency rate got %0d exp %0d", tag, got, m_rate[0]);
                end
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL %s complete_pulses got %0d exp 1", tag, pulses);
        end
        for (int i = 0; i < N; i++) begin
            got = bus.rate_out_bus[i*RW +: RW];
            checks++;
            if (int'(got) !== m_rate[i]) begin
                errors++;
                $display("FAIL %s axis%0d rate got %0d exp %0d", tag, i, got, m_rate[i]);
            end
            got = bus.angle_error_bus[i*RW +: RW];
            checks++;
            if (int'(got) !== m_err[i]) begin
                errors++;
                $display("FAIL %s axis%0d error got %0d exp %0d", tag, i, got, m_err[i]);
            end
            checks++;
            if (bus.saturated[i] !== m_sat[i]) begin
                errors++;
                $display("FAIL %s axis%0d saturated got %b exp %b", tag, i, bus.saturated[i], m_sat[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start_signal = 1'b0;
        bus.integ_clear  = 1'b0;
        set_neutral();
        drive_inputs();
        model_reset();
        repeat (3) @(posedge us_clk);
        #1;
        checks++;
        if (bus.rate_out_bus !== '0 || bus.angle_error_bus !== '0 || bus.saturated !== '0 ||
            bus.active_signal !== 1'b0 || bus.complete_signal !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rate=%h err=%h sat=%b act=%b cmp=%b exp all zero",
                     bus.rate_out_bus, bus.angle_error_bus, bus.saturated,
                     bus.active_signal, bus.complete_signal);
        end
        @(negedge us_clk) reset = 1'b0;

        tgt[0] = 200; act[0] = 32; tgt[1] = 250; act[1] = -160;
        drive_inputs();
        @(negedge us_clk) bus.start_signal = 1'b1;
        @(posedge us_clk);
        @(negedge us_clk) bus.start_signal = 1'b0;
        repeat (4) @(posedge us_clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.rate_out_bus !== '0 || bus.angle_error_bus !== '0 || bus.saturated !== '0 ||
            bus.active_signal !== 1'b0 || bus.complete_signal !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset got rate=%h err=%h sat=%b act=%b cmp=%b exp all zero",
                     bus.rate_out_bus, bus.angle_error_bus, bus.saturated,
                     bus.active_signal, bus.complete_signal);
        end
        @(negedge us_clk) reset = 1'b0;
        model_reset();
        run_and_check("after_reset", 0);
    endtask

    task automatic test_neutral();
        set_neutral();
        run_and_check("neutral", 0);
    endtask

    task automatic test_proportional();
        set_neutral();
        tgt[0] = 200; act[0] = 32;
        run_and_check("prop_kp16", 0);
        kp[0] = 8;
        run_and_check("prop_kp8", 0);
    endtask

    task automatic test_invert_saturation();
        set_neutral();
        tgt[1] = 250; act[1] = -160;
        run_and_check("invert0_sat", 0);
        inv[1] = 1'b1;
        run_and_check("invert1", 0);
    endtask

    task automatic test_integral();
        set_neutral();
        for (int i = 0; i < N; i++) kp[i] = 0;
        ki[0] = 16; tgt[0] = 175;
        pulse_clear();
        for (int r = 0; r < 3; r++) run_and_check("integral", 0);
        pulse_clear();
        run_and_check("integral_after_clear", 0);
        ki[0] = 255; tgt[0] = 125; act[0] = -2000;
        for (int r = 0; r < 3; r++) run_and_check("integral_windup", 0);
        act[0] = 50;
        run_and_check("integral_unwind", 0);
    endtask

    task automatic test_start_handling();
        set_neutral();
        tgt[2] = 140; act[2] = 10;
        run_and_check("start_held", 1);
        tgt[2] = 100;
        run_and_check("start_second_edge", 2);
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                tgt[i] = int'($urandom_range(255));
                act[i] = int'($urandom_range(2000)) - 1000;
                kp[i]  = int'($urandom_range(255));
                ki[i]  = int'($urandom_range(255));
                inv[i] = 1'($urandom_range(1));
            end
            if ($urandom_range(4) == 0) pulse_clear();
            run_and_check("random", 0);
        end
    endtask

    initial begin
        test_reset();
        test_neutral();
        test_proportional();
        test_invert_saturation();
        test_integral();
        test_start_handling();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
